// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM
// states, ALU-op codes (also used by the ALU control decoder) and mux selects.
package mips_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'h0,
        ST_DECODE  = 4'h1,
        ST_MEMADR  = 4'h2,
        ST_MEMRD   = 4'h3,
        ST_MEMWB   = 4'h4,
        ST_MEMWR   = 4'h5,
        ST_EXEC    = 4'h6,
        ST_RTYPEWB = 4'h7,
        ST_BRANCH  = 4'h8,
        ST_JUMP    = 4'h9,
        ST_IDLE    = 4'hF
    } state_e;

    localparam logic [1:0] OP_LS    = 2'b00;
    localparam logic [1:0] OP_BQ    = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control <-> datapath bundle: instruction opcode and memory handshake in,
// datapath enables and mux selects out.
interface mips_multicycle_control_if;

    logic [5:0] i_opcode;
    logic       i_memReady;
    logic       o_pcWrite;
    logic       o_pcWriteCond;
    logic       o_iorD;
    logic       o_memRead;
    logic       o_memWrite;
    logic       o_irWrite;
    logic       o_memToReg;
    logic       o_regDst;
    logic       o_regWrite;
    logic       o_aluSrcA;
    logic [1:0] o_aluSrcB;
    logic [1:0] o_aluOp;
    logic [1:0] o_pcSource;
    logic       o_illegal;
    logic [3:0] o_state;

    // Controller side
    modport master (
        input  i_opcode, i_memReady,
        output o_pcWrite, o_pcWriteCond, o_iorD, o_memRead, o_memWrite,
               o_irWrite, o_memToReg, o_regDst, o_regWrite, o_aluSrcA,
               o_aluSrcB, o_aluOp, o_pcSource, o_illegal, o_state
    );

    // Datapath side
    modport slave (
        output i_opcode, i_memReady,
        input  o_pcWrite, o_pcWriteCond, o_iorD, o_memRead, o_memWrite,
               o_irWrite, o_memToReg, o_regDst, o_regWrite, o_aluSrcA,
               o_aluSrcB, o_aluOp, o_pcSource, o_illegal, o_state
    );

endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (R-type, lw, sw, beq, j).
// Outputs decode from the state register; FETCH's PC/IR loads are gated by
// the memory-ready handshake so a stall never double-increments the PC.
module mips_multicycle_control
    import mips_pkg::*;
(
    input logic                         i_clk,
    input logic                         i_rst,
    mips_multicycle_control_if.master   bus
);

    state_e state_q;
    state_e state_d;

    // State register with synchronous reset to IDLE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; opcode only consulted in DECODE and MEMADR
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = ST_FETCH;
            ST_FETCH:   state_d = bus.i_memReady ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (bus.i_opcode)
                    OPC_LW, OPC_SW: state_d = ST_MEMADR;
                    OPC_RTYPE:      state_d = ST_EXEC;
                    OPC_BEQ:        state_d = ST_BRANCH;
                    OPC_J:          state_d = ST_JUMP;
                    default:        state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR:  state_d = (bus.i_opcode == OPC_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:   state_d = bus.i_memReady ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:   state_d = bus.i_memReady ? ST_FETCH : ST_MEMWR;
            ST_MEMWB:   state_d = ST_FETCH;
            ST_EXEC:    state_d = ST_RTYPEWB;
            ST_RTYPEWB: state_d = ST_FETCH;
            ST_BRANCH:  state_d = ST_FETCH;
            ST_JUMP:    state_d = ST_FETCH;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode; every control defaults low
    always_comb begin
        bus.o_pcWrite     = 1'b0;
        bus.o_pcWriteCond = 1'b0;
        bus.o_iorD        = 1'b0;
        bus.o_memRead     = 1'b0;
        bus.o_memWrite    = 1'b0;
        bus.o_irWrite     = 1'b0;
        bus.o_memToReg    = 1'b0;
        bus.o_regDst      = 1'b0;
        bus.o_regWrite    = 1'b0;
        bus.o_aluSrcA     = 1'b0;
        bus.o_aluSrcB     = SRCB_RT;
        bus.o_aluOp       = OP_LS;
        bus.o_pcSource    = PCSRC_ALU;
        bus.o_illegal     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus.o_memRead  = 1'b1;
                bus.o_aluSrcB  = SRCB_FOUR;
                bus.o_aluOp    = OP_LS;
                bus.o_pcSource = PCSRC_ALU;
                bus.o_pcWrite  = bus.i_memReady;
                bus.o_irWrite  = bus.i_memReady;
            end
            ST_DECODE: begin
                bus.o_aluSrcB = SRCB_IMM_SH;
                bus.o_aluOp   = OP_LS;
                case (bus.i_opcode)
                    OPC_LW, OPC_SW, OPC_RTYPE, OPC_BEQ, OPC_J: bus.o_illegal = 1'b0;
                    default:                                   bus.o_illegal = 1'b1;
                endcase
            end
            ST_MEMADR: begin
                bus.o_aluSrcA = 1'b1;
                bus.o_aluSrcB = SRCB_IMM;
                bus.o_aluOp   = OP_LS;
            end
            ST_MEMRD: begin
                bus.o_memRead = 1'b1;
                bus.o_iorD    = 1'b1;
            end
            ST_MEMWB: begin
                bus.o_regWrite = 1'b1;
                bus.o_memToReg = 1'b1;
                bus.o_regDst   = 1'b0;
            end
            ST_MEMWR: begin
                bus.o_memWrite = 1'b1;
                bus.o_iorD     = 1'b1;
            end
            ST_EXEC: begin
                bus.o_aluSrcA = 1'b1;
                bus.o_aluSrcB = SRCB_RT;
                bus.o_aluOp   = OP_RTYPE;
            end
            ST_RTYPEWB: begin
                bus.o_regWrite = 1'b1;
                bus.o_regDst   = 1'b1;
            end
            ST_BRANCH: begin
                bus.o_aluSrcA     = 1'b1;
                bus.o_aluOp       = OP_BQ;
                bus.o_pcWriteCond = 1'b1;
                bus.o_pcSource    = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                bus.o_pcWrite  = 1'b1;
                bus.o_pcSource = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign bus.o_state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: a per-cycle vector table plus a
// hand-driven sw sequence with FETCH and MEMWR stalls.
module tb_mips_multicycle_control;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] out;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    // Pack order: pcW pcWC iorD memR memW irW m2r regDst regW srcA srcB aluOp pcSrc ill
    function automatic logic [16:0] pk(
        input logic pcw, pcwc, iord, memr, memw, irw, m2r, rdst, regw, srca,
        input logic [1:0] srcb, aluop, pcsrc,
        input logic ill);
        return {pcw, pcwc, iord, memr, memw, irw, m2r, rdst, regw, srca, srcb, aluop, pcsrc, ill};
    endfunction

    function automatic logic [16:0] actual_out();
        return {bus.o_pcWrite, bus.o_pcWriteCond, bus.o_iorD, bus.o_memRead,
                bus.o_memWrite, bus.o_irWrite, bus.o_memToReg, bus.o_regDst,
                bus.o_regWrite, bus.o_aluSrcA, bus.o_aluSrcB, bus.o_aluOp,
                bus.o_pcSource, bus.o_illegal};
    endfunction

    function automatic void add(input logic r, input logic [5:0] op, input logic rdy,
                                input logic [3:0] st, input logic [16:0] out);
        vec_t v;
        v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.out = out;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;

    logic [16:0] o_idle, o_fetch, o_fetch_stall, o_dec, o_dec_ill, o_madr, o_mrd,
                 o_mwb, o_mwr, o_exec, o_rwb, o_br, o_jmp;

    initial begin
        o_idle        = '0;
        o_fetch       = pk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
        o_fetch_stall = pk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        o_dec         = pk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
        o_dec_ill     = pk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
        o_madr        = pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        o_mrd         = pk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        o_mwb         = pk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
        o_mwr         = pk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        o_exec        = pk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
        o_rwb         = pk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
        o_br          = pk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        o_jmp         = pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);

        // reset state
        add(0, LW, 1, 4'hF, o_idle);
        // lw, no stalls
        add(0, LW, 1, 4'h0, o_fetch);
        add(0, LW, 1, 4'h1, o_dec);
        add(0, LW, 1, 4'h2, o_madr);
        add(0, LW, 1, 4'h3, o_mrd);
        add(0, LW, 1, 4'h4, o_mwb);
        // R-type
        add(0, RT, 1, 4'h0, o_fetch);
        add(0, RT, 1, 4'h1, o_dec);
        add(0, RT, 1, 4'h6, o_exec);
        add(0, RT, 1, 4'h7, o_rwb);
        // beq then j
        add(0, BEQ, 1, 4'h0, o_fetch);
        add(0, BEQ, 1, 4'h1, o_dec);
        add(0, BEQ, 1, 4'h8, o_br);
        add(0, JMP, 1, 4'h0, o_fetch);
        add(0, JMP, 1, 4'h1, o_dec);
        add(0, JMP, 1, 4'h9, o_jmp);
        // sw with three MEMWR stall cycles
        add(0, SW, 1, 4'h0, o_fetch);
        add(0, SW, 1, 4'h1, o_dec);
        add(0, SW, 1, 4'h2, o_madr);
        add(0, SW, 0, 4'h5, o_mwr);
        add(0, SW, 0, 4'h5, o_mwr);
        add(0, SW, 0, 4'h5, o_mwr);
        add(0, SW, 1, 4'h5, o_mwr);
        // FETCH stalled two cycles, then illegal opcode
        add(0, BAD, 0, 4'h0, o_fetch_stall);
        add(0, BAD, 0, 4'h0, o_fetch_stall);
        add(0, BAD, 1, 4'h0, o_fetch);
        add(0, BAD, 1, 4'h1, o_dec_ill);
        // lw with reset asserted during a MEMRD stall
        add(0, LW, 1, 4'h0, o_fetch);
        add(0, LW, 1, 4'h1, o_dec);
        add(0, LW, 1, 4'h2, o_madr);
        add(1, LW, 0, 4'h3, o_mrd);
        add(0, LW, 1, 4'hF, o_idle);
        // sw aborted by reset in MEMWR
        add(0, SW, 1, 4'h0, o_fetch);
        add(0, SW, 1, 4'h1, o_dec);
        add(0, SW, 1, 4'h2, o_madr);
        add(1, SW, 0, 4'h5, o_mwr);
        add(0, SW, 0, 4'hF, o_idle);
        add(0, SW, 0, 4'h0, o_fetch_stall);
    end

    initial begin
        int mw_cnt, pcw_cnt, irw_cnt, fetch_stalls, mwr_stalls;
        logic seen_mwr, ready_in_mwr, done;

        rst = 1'b1;
        bus.i_opcode   = '0;
        bus.i_memReady = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst            = vecs[i].rst;
            bus.i_opcode   = vecs[i].op;
            bus.i_memReady = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_state", i), 32'(bus.o_state), 32'(vecs[i].st));
            check($sformatf("vec%0d_out", i), 32'(actual_out()), 32'(vecs[i].out));
        end

        // sw with FETCH stalled 2 cycles and MEMWR stalled 3 cycles
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_opcode = SW;
        mw_cnt = 0; pcw_cnt = 0; irw_cnt = 0; fetch_stalls = 0; mwr_stalls = 0;
        seen_mwr = 1'b0; ready_in_mwr = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (ready_in_mwr) begin
                check("fetch_after_ready", 32'(bus.o_state), 32'h0);
                done = 1'b1;
                break;
            end
            bus.i_memReady = 1'b1;
            if (bus.o_state == 4'h0 && fetch_stalls < 2) begin
                bus.i_memReady = 1'b0;
                fetch_stalls++;
            end
            if (bus.o_state == 4'h5 && mwr_stalls < 3) begin
                bus.i_memReady = 1'b0;
                mwr_stalls++;
            end
            #1;
            if (bus.o_memWrite) mw_cnt++;
            if (bus.o_pcWrite)  pcw_cnt++;
            if (bus.o_irWrite)  irw_cnt++;
            if (bus.o_state == 4'h5) seen_mwr = 1'b1;
            if (seen_mwr && bus.o_state == 4'h5 && bus.i_memReady) ready_in_mwr = 1'b1;
        end
        check("sw_completed_in_budget", 32'(done), 32'h1);
        check("sw_memwrite_cycles", 32'(mw_cnt), 32'd4);
        check("fetch_pcwrite_pulses", 32'(pcw_cnt), 32'd1);
        check("fetch_irwrite_pulses", 32'(irw_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
